// File: rtl/multdiv_issue_ctrl.sv
// Issue/stall sequencer for the shared multi-cycle multiply/divide unit in execute.
// Latches operands, pulses start once, stalls the pipe and presents the result for one cycle.
module multdiv_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7,
  parameter int MUL_EXC = 4,
  parameter int DIV_EXC = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_is_mult,
  input  logic             ex_is_div,
  input  logic [WIDTH-1:0] ex_opA,
  input  logic [WIDTH-1:0] ex_opB,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] md_opA,
  output logic [WIDTH-1:0] md_opB,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_exception,
  input  logic             md_ready,
  output logic             stall,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic [4:0]       res_rd,
  output logic             res_exc,
  output logic             busy,
  output logic             timeout_err
);

  localparam logic [4:0] EXC_RD = 5'd30;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_lat;
  logic             op_mult;
  logic             accept;
  logic             start_cyc;
  logic             ready_ok;
  logic             timed_out;

  function automatic logic [WIDTH-1:0] exc_code(input logic is_mul);
    return is_mul ? WIDTH'(MUL_EXC) : WIDTH'(DIV_EXC);
  endfunction

  assign accept    = ex_valid & (ex_is_mult | ex_is_div) & ~flush;
  // A ready coinciding with the start pulse belongs to no operation of ours.
  assign start_cyc = md_ctrl_mult | md_ctrl_div;
  assign ready_ok  = md_ready & ~start_cyc;
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    res_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        stall = accept;
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (flush)          state_nxt = IDLE;
        else if (ready_ok)  state_nxt = DONE;
        else if (timed_out) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stage p0: operand capture / start pulse; stage p1: result capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      md_opA       <= '0;
      md_opB       <= '0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      rd_lat       <= '0;
      op_mult      <= 1'b0;
      res_data     <= '0;
      res_rd       <= '0;
      res_exc      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            md_opA       <= ex_opA;
            md_opB       <= ex_opB;
            rd_lat       <= ex_rd;
            op_mult      <= ex_is_mult;
            md_ctrl_mult <= ex_is_mult;
            md_ctrl_div  <= ~ex_is_mult;
            cnt          <= '0;
          end
        end
        BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (!flush) begin
            if (ready_ok) begin
              res_data <= md_exception ? exc_code(op_mult) : md_result;
              res_rd   <= md_exception ? EXC_RD : rd_lat;
              res_exc  <= md_exception;
            end else if (timed_out) begin
              res_data    <= '0;
              res_rd      <= EXC_RD;
              res_exc     <= 1'b1;
              timeout_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl: table of operations plus flush/timeout/reset sequences.
module tb_multdiv_issue_ctrl;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          ex_valid, ex_is_mult, ex_is_div, flush;
  logic [W-1:0]  ex_opA, ex_opB;
  logic [4:0]    ex_rd;
  logic [W-1:0]  md_opA, md_opB, md_result, res_data;
  logic          md_ctrl_mult, md_ctrl_div, md_exception, md_ready;
  logic          stall, res_valid, res_exc, busy, timeout_err;
  logic [4:0]    res_rd;

  multdiv_issue_ctrl #(.WIDTH(W), .TIMEOUT(64), .CNT_W(7), .MUL_EXC(4), .DIV_EXC(5)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .ex_is_mult(ex_is_mult),
    .ex_is_div(ex_is_div), .ex_opA(ex_opA), .ex_opB(ex_opB), .ex_rd(ex_rd), .flush(flush),
    .md_opA(md_opA), .md_opB(md_opB), .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready), .stall(stall),
    .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd), .res_exc(res_exc),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] data;
    logic [4:0]   rd;
    logic         exc;
  } res_t;

  typedef struct {
    bit          is_mult;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]  rd;
    int          delay;
    bit          exc;
    bit          early;
  } vec_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   errors = 0;
  int   checks = 0;
  int   nmul = 0;
  int   ndiv = 0;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample outputs on the falling edge, record strobes and pulses.
  task automatic tick();
    @(negedge clock);
    if (res_valid === 1'b1) obs_q.push_back('{data: res_data, rd: res_rd, exc: res_exc});
    if (md_ctrl_mult === 1'b1) nmul++;
    if (md_ctrl_div === 1'b1) ndiv++;
  endtask

  task automatic sb_drain();
    res_t o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        check("res_unexpected", 64'(o.data), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("res_data", 64'(o.data), 64'(e.data));
        check("res_rd", 64'(o.rd), 64'(e.rd));
        check("res_exc", 64'(o.exc), 64'(e.exc));
      end
    end
    check("res_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic drive_ex(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_mult = is_mult; ex_is_div = !is_mult;
    ex_opA = a; ex_opB = b; ex_rd = rd;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_is_mult = 1'b0; ex_is_div = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    res_t        e;
    int          m0, d0;
    bit          stall_ok;
    logic [W-1:0] r;
    r = v.is_mult ? v.a * v.b : ((v.b == 0) ? 32'hFFFF_FFFF : v.a / v.b);
    e.data = v.exc ? (v.is_mult ? 32'd4 : 32'd5) : r;
    e.rd   = v.exc ? 5'd30 : v.rd;
    e.exc  = v.exc;
    tick();
    m0 = nmul; d0 = ndiv;
    drive_ex(v.is_mult, v.a, v.b, v.rd);
    #1 check("stall_accept", 64'(stall), 64'd1);
    tick();
    check("md_opA", 64'(md_opA), 64'(v.a));
    check("md_opB", 64'(md_opB), 64'(v.b));
    if (v.early) begin
      md_ready = 1'b1; md_result = 32'hDEAD_BEEF; md_exception = 1'b1;
    end
    stall_ok = 1'b1;
    repeat (v.delay) begin
      tick();
      md_ready = 1'b0; md_exception = 1'b0;
      if (!(stall === 1'b1 && busy === 1'b1 && res_valid === 1'b0)) stall_ok = 1'b0;
    end
    md_ready = 1'b1; md_result = r; md_exception = v.exc;
    exp_q.push_back(e);
    tick();
    md_ready = 1'b0; md_exception = 1'b0; md_result = '0;
    check("stall_held", 64'(stall_ok), 64'd1);
    #1;
    check("stall_done", 64'(stall), 64'd0);
    check("res_valid_done", 64'(res_valid), 64'd1);
    tick();
    clear_ex();
    #1 check("busy_after", 64'(busy), 64'd0);
    check("pulses", 64'((nmul - m0) * 2 + (ndiv - d0)), 64'(v.is_mult ? 2 : 1));
    sb_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    int   m0;
    vecs[0] = '{1'b1, 32'd7,          32'd6,          5'd5,  33, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'd100,        32'd0,          5'd7,  10, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h4000_0000,  32'd4,          5'd9,  20, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'd100,        32'd7,          5'd12,  3, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd31,  1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h8000_0000,  32'd2,          5'd1,  35, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'd3,          32'd5,          5'd2,   5, 1'b0, 1'b1};

    reset = 1'b0; flush = 1'b0; md_ready = 1'b0; md_exception = 1'b0; md_result = '0;
    ex_opA = '0; ex_opB = '0; ex_rd = '0;
    clear_ex();
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_ctrl", 64'({md_ctrl_mult, md_ctrl_div}), 64'd0);
    check("rst_res", 64'({res_data, res_rd, res_exc}), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    // Timeout: no ready ever; 64 BUSY cycles then DONE.
    tick();
    drive_ex(1'b1, 32'd3, 32'd3, 5'd4);
    exp_q.push_back('{data: 32'd0, rd: 5'd30, exc: 1'b1});
    tick();
    repeat (63) tick();
    check("to_busy64", 64'({busy, res_valid}), 64'b10);
    tick();
    check("to_done", 64'(res_valid), 64'd1);
    check("to_err", 64'(timeout_err), 64'd1);
    tick();
    clear_ex();
    sb_drain();
    run_op(vecs[3]);
    check("to_sticky", 64'(timeout_err), 64'd1);

    // Flush 10 cycles into BUSY; a late ready must be ignored.
    tick();
    drive_ex(1'b0, 32'd9, 32'd3, 5'd8);
    tick();
    repeat (10) tick();
    flush = 1'b1;
    #1 check("flush_stall_hi", 64'(stall), 64'd1);
    tick();
    flush = 1'b0;
    clear_ex();
    #1;
    check("flush_stall_lo", 64'(stall), 64'd0);
    check("flush_busy", 64'(busy), 64'd0);
    md_ready = 1'b1; md_result = 32'd77;
    tick();
    md_ready = 1'b0;
    tick();
    tick();
    check("flush_no_res", 64'(obs_q.size()), 64'd0);
    sb_drain();

    // Asynchronous reset in mid-BUSY, then a normal div after release.
    tick();
    m0 = ndiv;
    drive_ex(1'b0, 32'd50, 32'd5, 5'd3);
    tick();
    tick();
    tick();
    #2;
    reset = 1'b0;
    clear_ex();
    #1;
    check("arst_busy_stall", 64'({busy, stall}), 64'd0);
    check("arst_md_ops", 64'({md_opA, md_opB}), 64'd0);
    check("arst_res", 64'({res_data, res_rd, res_exc}), 64'd0);
    check("arst_timeout", 64'(timeout_err), 64'd0);
    check("arst_pulse_once", 64'(ndiv - m0), 64'd1);
    tick();
    tick();
    reset = 1'b1;
    vecs[0] = '{1'b0, 32'd50, 32'd5, 5'd3, 4, 1'b0, 1'b0};
    run_op(vecs[0]);
    check("timeout_clear", 64'(timeout_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
